// File: rtl/mips_pkg.sv
// Shared MIPS decode definitions: opcodes, ALU op codes,
// the ID-stage control bundle and the IF/ID latch layout.
package mips_pkg;

    localparam logic [5:0] OP_RTYPE = 6'h00;
    localparam logic [5:0] OP_J     = 6'h02;
    localparam logic [5:0] OP_BEQ   = 6'h04;
    localparam logic [5:0] OP_BNE   = 6'h05;
    localparam logic [5:0] OP_ADDI  = 6'h08;
    localparam logic [5:0] OP_SLTI  = 6'h0A;
    localparam logic [5:0] OP_ANDI  = 6'h0C;
    localparam logic [5:0] OP_ORI   = 6'h0D;
    localparam logic [5:0] OP_LUI   = 6'h0F;
    localparam logic [5:0] OP_LW    = 6'h23;
    localparam logic [5:0] OP_SW    = 6'h2B;

    localparam logic [2:0] ALU_ADD   = 3'b000;
    localparam logic [2:0] ALU_SUB   = 3'b001;
    localparam logic [2:0] ALU_FUNCT = 3'b010;
    localparam logic [2:0] ALU_AND   = 3'b011;
    localparam logic [2:0] ALU_OR    = 3'b100;
    localparam logic [2:0] ALU_SLT   = 3'b101;
    localparam logic [2:0] ALU_LUI   = 3'b110;

    localparam logic [31:0] NOP_INSTR = 32'h0000_0000;

    typedef struct packed {
        logic       reg_dst;
        logic       alu_src;
        logic       mem_to_reg;
        logic       reg_write;
        logic       mem_read;
        logic       mem_write;
        logic [2:0] alu_op;
    } ctrl_t;

    localparam ctrl_t CTRL_NOP = '0;

    typedef struct packed {
        logic [31:0] instr;
        logic [31:0] pc_plus4;
        logic        valid;
    } if_id_t;

endpackage

// File: rtl/id_stage_regfile.sv
// Register file with r0 hardwired to zero and a write-through
// bypass so a same-cycle write-back is visible to decode.
module id_stage_regfile #(
    parameter int NREG = 32,
    parameter int XLEN = 32
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            we,
    input  logic [4:0]      waddr,
    input  logic [XLEN-1:0] wdata,
    input  logic [4:0]      raddr_a,
    input  logic [4:0]      raddr_b,
    output logic [XLEN-1:0] rdata_a,
    output logic [XLEN-1:0] rdata_b
);

    logic [XLEN-1:0] regs [NREG];
    logic            wr_en;

    assign wr_en = we && (waddr != 5'd0);

    // Synchronous clear; write-back ignored while in reset.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            for (int i = 0; i < NREG; i++) begin
                regs[i] <= '0;
            end
        end else if (wr_en) begin
            regs[waddr] <= wdata;
        end
    end

    // Port A read: r0 is zero, else bypass, else array.
    always_comb begin
        rdata_a = regs[raddr_a];
        if (wr_en && waddr == raddr_a) begin
            rdata_a = wdata;
        end
        if (raddr_a == 5'd0) begin
            rdata_a = '0;
        end
    end

    // Port B read: same rules as port A.
    always_comb begin
        rdata_b = regs[raddr_b];
        if (wr_en && waddr == raddr_b) begin
            rdata_b = wdata;
        end
        if (raddr_b == 5'd0) begin
            rdata_b = '0;
        end
    end

endmodule

// File: rtl/id_stage.sv
// MIPS decode stage: IF/ID latch, register read, control decode,
// immediate extension, early branch resolution, hazard stalls.
module id_stage
    import mips_pkg::*;
#(
    parameter int NREG = 32,
    parameter int XLEN = 32
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic [31:0]     if_instr,
    input  logic [XLEN-1:0] if_pc_plus4,
    input  logic            wb_we,
    input  logic [4:0]      wb_addr,
    input  logic [XLEN-1:0] wb_data,
    input  logic            ex_reg_write,
    input  logic            ex_mem_read,
    input  logic [4:0]      ex_dest,
    input  logic            mem_mem_read,
    input  logic [4:0]      mem_dest,
    output logic [XLEN-1:0] rs_data,
    output logic [XLEN-1:0] rt_data,
    output logic [XLEN-1:0] imm_ext,
    output logic [4:0]      rs,
    output logic [4:0]      rt,
    output logic [4:0]      rd,
    output logic [4:0]      shamt,
    output logic [5:0]      funct,
    output logic            reg_dst,
    output logic            alu_src,
    output logic            mem_to_reg,
    output logic            reg_write,
    output logic            mem_read,
    output logic            mem_write,
    output logic [2:0]      alu_op,
    output logic            stall,
    output logic            pc_src,
    output logic [XLEN-1:0] pc_target,
    output logic            flush_if
);

    if_id_t     ifid;
    ctrl_t      dec;
    ctrl_t      ctrl;
    logic [5:0] opcode;
    logic       is_br;
    logic       is_j;
    logic       rt_src;
    logic       zext;
    logic       load_use;
    logic       br_dep;
    logic       br_load;
    logic       taken;
    logic       jump;

    // IF/ID latch: reset, then stall hold, then flush, then load.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            ifid <= '{instr: NOP_INSTR, pc_plus4: '0, valid: 1'b0};
        end else if (stall) begin
            ifid <= ifid;
        end else if (flush_if) begin
            ifid <= '{instr: NOP_INSTR, pc_plus4: if_pc_plus4,
                      valid: 1'b0};
        end else begin
            ifid <= '{instr: if_instr, pc_plus4: if_pc_plus4,
                      valid: 1'b1};
        end
    end

    assign opcode = ifid.instr[31:26];
    assign rs     = ifid.instr[25:21];
    assign rt     = ifid.instr[20:16];
    assign rd     = ifid.instr[15:11];
    assign shamt  = ifid.instr[10:6];
    assign funct  = ifid.instr[5:0];

    id_stage_regfile #(
        .NREG(NREG),
        .XLEN(XLEN)
    ) u_rf (
        .clk    (clk),
        .rst_n  (rst_n),
        .we     (wb_we),
        .waddr  (wb_addr),
        .wdata  (wb_data),
        .raddr_a(rs),
        .raddr_b(rt),
        .rdata_a(rs_data),
        .rdata_b(rt_data)
    );

    // Main control decode by opcode; unknown opcodes act as NOP.
    always_comb begin
        dec    = CTRL_NOP;
        is_br  = 1'b0;
        is_j   = 1'b0;
        rt_src = 1'b0;
        zext   = 1'b0;
        unique case (opcode)
            OP_RTYPE: begin
                dec.reg_dst   = 1'b1;
                dec.reg_write = 1'b1;
                dec.alu_op    = ALU_FUNCT;
                rt_src        = 1'b1;
            end
            OP_LW: begin
                dec.alu_src    = 1'b1;
                dec.mem_to_reg = 1'b1;
                dec.reg_write  = 1'b1;
                dec.mem_read   = 1'b1;
                dec.alu_op     = ALU_ADD;
            end
            OP_SW: begin
                dec.alu_src   = 1'b1;
                dec.mem_write = 1'b1;
                dec.alu_op    = ALU_ADD;
                rt_src        = 1'b1;
            end
            OP_ADDI, OP_SLTI, OP_LUI: begin
                dec.alu_src   = 1'b1;
                dec.reg_write = 1'b1;
                dec.alu_op    = (opcode == OP_ADDI) ? ALU_ADD
                              : (opcode == OP_SLTI) ? ALU_SLT
                              : ALU_LUI;
            end
            OP_ANDI, OP_ORI: begin
                dec.alu_src   = 1'b1;
                dec.reg_write = 1'b1;
                dec.alu_op    = (opcode == OP_ANDI) ? ALU_AND : ALU_OR;
                zext          = 1'b1;
            end
            OP_BEQ, OP_BNE: begin
                dec.alu_op = ALU_SUB;
                is_br      = 1'b1;
                rt_src     = 1'b1;
            end
            OP_J: begin
                is_j = 1'b1;
            end
            default: begin
                dec = CTRL_NOP;
            end
        endcase
    end

    assign imm_ext = zext ? {{(XLEN-16){1'b0}}, ifid.instr[15:0]}
                          : {{(XLEN-16){ifid.instr[15]}}, ifid.instr[15:0]};

    assign load_use = ex_mem_read && ex_dest != 5'd0
                   && (ex_dest == rs || (rt_src && ex_dest == rt));
    assign br_dep   = is_br && ex_reg_write && ex_dest != 5'd0
                   && (ex_dest == rs || ex_dest == rt);
    assign br_load  = is_br && mem_mem_read && mem_dest != 5'd0
                   && (mem_dest == rs || mem_dest == rt);
    assign stall    = ifid.valid && (load_use || br_dep || br_load);

    assign ctrl = (ifid.valid && !stall) ? dec : CTRL_NOP;

    assign reg_dst    = ctrl.reg_dst;
    assign alu_src    = ctrl.alu_src;
    assign mem_to_reg = ctrl.mem_to_reg;
    assign reg_write  = ctrl.reg_write;
    assign mem_read   = ctrl.mem_read;
    assign mem_write  = ctrl.mem_write;
    assign alu_op     = ctrl.alu_op;

    assign taken = ifid.valid && !stall
                && ((opcode == OP_BEQ && rs_data == rt_data)
                 || (opcode == OP_BNE && rs_data != rt_data));
    assign jump  = ifid.valid && !stall && is_j;

    assign pc_src    = taken || jump;
    assign flush_if  = taken || jump;
    assign pc_target = is_j
        ? {ifid.pc_plus4[XLEN-1:28], ifid.instr[25:0], 2'b00}
        : ifid.pc_plus4 + {imm_ext[XLEN-3:0], 2'b00};

endmodule

// File: tb/tb_id_stage.sv
// Scoreboard bench for id_stage: directed scenarios plus random
// traffic checked against a behavioural decode model.
module tb_id_stage;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [31:0] if_instr, if_pc_plus4;
    logic        wb_we;
    logic [4:0]  wb_addr;
    logic [31:0] wb_data;
    logic        ex_reg_write, ex_mem_read;
    logic [4:0]  ex_dest;
    logic        mem_mem_read;
    logic [4:0]  mem_dest;
    logic [31:0] rs_data, rt_data, imm_ext, pc_target;
    logic [4:0]  rs, rt, rd, shamt;
    logic [5:0]  funct;
    logic        reg_dst, alu_src, mem_to_reg, reg_write;
    logic        mem_read, mem_write;
    logic [2:0]  alu_op;
    logic        stall, pc_src, flush_if;

    always #5 clk = ~clk;

    id_stage dut (
        .clk(clk), .rst_n(rst_n),
        .if_instr(if_instr), .if_pc_plus4(if_pc_plus4),
        .wb_we(wb_we), .wb_addr(wb_addr), .wb_data(wb_data),
        .ex_reg_write(ex_reg_write), .ex_mem_read(ex_mem_read),
        .ex_dest(ex_dest), .mem_mem_read(mem_mem_read),
        .mem_dest(mem_dest),
        .rs_data(rs_data), .rt_data(rt_data), .imm_ext(imm_ext),
        .rs(rs), .rt(rt), .rd(rd), .shamt(shamt), .funct(funct),
        .reg_dst(reg_dst), .alu_src(alu_src),
        .mem_to_reg(mem_to_reg), .reg_write(reg_write),
        .mem_read(mem_read), .mem_write(mem_write),
        .alu_op(alu_op), .stall(stall), .pc_src(pc_src),
        .pc_target(pc_target), .flush_if(flush_if)
    );

    typedef struct {
        int          cyc;
        logic [31:0] rsd, rtd, imm, tgt;
        logic [4:0]  rs, rt, rd, sh;
        logic [5:0]  fn;
        logic [8:0]  ctrl;
        logic        stall, pcs, fl;
    } exp_t;

    typedef struct {
        int          cyc;
        int          sel;
        logic [31:0] val;
    } lit_t;

    exp_t q[$];
    lit_t lq[$];

    int tests = 0;
    int failed = 0;
    int cyc = 0;
    bit known = 0;

    logic [31:0] mreg [32];
    logic [31:0] m_instr, m_pc;
    logic        m_valid;

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            failed++;
            $display("FAIL %s cyc: got %h expected %h", nm, act, exp);
        end
    endtask

    // Control bundle {reg_dst,alu_src,mem_to_reg,reg_write,
    // mem_read,mem_write,alu_op} from the opcode table.
    function automatic logic [8:0] ctrl_for(input logic [5:0] op);
        case (op)
            6'h00: return 9'b100100_010;
            6'h23: return 9'b011110_000;
            6'h2B: return 9'b010001_000;
            6'h08: return 9'b010100_000;
            6'h0C: return 9'b010100_011;
            6'h0D: return 9'b010100_100;
            6'h0A: return 9'b010100_101;
            6'h0F: return 9'b010100_110;
            6'h04: return 9'b000000_001;
            6'h05: return 9'b000000_001;
            default: return 9'b0;
        endcase
    endfunction

    function automatic logic [31:0] rtype(input int s, input int t,
                                          input int d);
        return {6'h00, 5'(s), 5'(t), 5'(d), 5'd0, 6'h20};
    endfunction

    function automatic logic [31:0] itype(input logic [5:0] op,
                                          input int s, input int t,
                                          input logic [15:0] im);
        return {op, 5'(s), 5'(t), im};
    endfunction

    function automatic logic [31:0] rdreg(input logic [4:0] a);
        if (a == 0) return 0;
        if (wb_we && wb_addr == a) return wb_data;
        return mreg[a];
    endfunction

    task automatic step(input logic r, input logic [31:0] ins,
                        input logic [31:0] pc, input logic we,
                        input logic [4:0] wa, input logic [31:0] wd,
                        input logic erw, input logic emr,
                        input logic [4:0] ed, input logic mmr,
                        input logic [4:0] md);
        exp_t e;
        logic [5:0] op;
        logic [4:0] s, t;
        logic [31:0] a, b, im;
        logic isbr, rsrc, st, tk, jp;
        @(posedge clk);
        #1;
        rst_n = r; if_instr = ins; if_pc_plus4 = pc;
        wb_we = we; wb_addr = wa; wb_data = wd;
        ex_reg_write = erw; ex_mem_read = emr; ex_dest = ed;
        mem_mem_read = mmr; mem_dest = md;
        cyc++;
        op = m_instr[31:26];
        s = m_instr[25:21];
        t = m_instr[20:16];
        a = rdreg(s);
        b = rdreg(t);
        im = (op == 6'h0C || op == 6'h0D) ? {16'h0, m_instr[15:0]}
           : {{16{m_instr[15]}}, m_instr[15:0]};
        isbr = (op == 6'h04 || op == 6'h05);
        rsrc = isbr || op == 6'h00 || op == 6'h2B;
        st = m_valid && (
             (emr && ed != 0 && (ed == s || (rsrc && ed == t)))
          || (isbr && erw && ed != 0 && (ed == s || ed == t))
          || (isbr && mmr && md != 0 && (md == s || md == t)));
        tk = m_valid && !st && ((op == 6'h04 && a == b)
                              || (op == 6'h05 && a != b));
        jp = m_valid && !st && op == 6'h02;
        if (known) begin
            e.cyc = cyc;
            e.rsd = a; e.rtd = b; e.imm = im;
            e.rs = s; e.rt = t; e.rd = m_instr[15:11];
            e.sh = m_instr[10:6]; e.fn = m_instr[5:0];
            e.ctrl = (m_valid && !st) ? ctrl_for(op) : 9'b0;
            e.stall = st; e.pcs = tk || jp; e.fl = tk || jp;
            e.tgt = jp ? {m_pc[31:28], m_instr[25:0], 2'b00}
                       : m_pc + (im << 2);
            q.push_back(e);
        end
        if (!r) begin
            foreach (mreg[i]) mreg[i] = 0;
            m_instr = 0; m_pc = 0; m_valid = 0;
            known = 1;
        end else begin
            if (we && wa != 0) mreg[wa] = wd;
            if (!st) begin
                if (tk || jp) begin
                    m_instr = 0; m_valid = 0; m_pc = pc;
                end else begin
                    m_instr = ins; m_valid = 1; m_pc = pc;
                end
            end
        end
    endtask

    task automatic lit(input int sel, input logic [31:0] v);
        lit_t l;
        l.cyc = cyc; l.sel = sel; l.val = v;
        lq.push_back(l);
    endtask

    function automatic logic [8:0] act_ctrl();
        return {reg_dst, alu_src, mem_to_reg, reg_write,
                mem_read, mem_write, alu_op};
    endfunction

    // Monitor: compare every presented cycle against the scoreboard.
    initial begin
        exp_t e;
        lit_t l;
        forever begin
            @(negedge clk);
            if (q.size() > 0) begin
                e = q.pop_front();
                chk("rs_data", rs_data, e.rsd);
                chk("rt_data", rt_data, e.rtd);
                chk("imm_ext", imm_ext, e.imm);
                chk("rs", rs, e.rs);
                chk("rt", rt, e.rt);
                chk("rd", rd, e.rd);
                chk("shamt", shamt, e.sh);
                chk("funct", funct, e.fn);
                chk("ctrl", act_ctrl(), e.ctrl);
                chk("stall", stall, e.stall);
                chk("pc_src", pc_src, e.pcs);
                chk("flush_if", flush_if, e.fl);
                if (e.pcs) chk("pc_target", pc_target, e.tgt);
                while (lq.size() > 0 && lq[0].cyc == e.cyc) begin
                    l = lq.pop_front();
                    case (l.sel)
                        0: chk("lit_rs_data", rs_data, l.val);
                        1: chk("lit_rt_data", rt_data, l.val);
                        2: chk("lit_imm_ext", imm_ext, l.val);
                        3: chk("lit_stall", stall, l.val);
                        4: chk("lit_pc_src", pc_src, l.val);
                        5: chk("lit_flush_if", flush_if, l.val);
                        6: chk("lit_pc_target", pc_target, l.val);
                        7: chk("lit_ctrl", act_ctrl(), l.val);
                        default: chk("lit_rs", rs, l.val);
                    endcase
                end
            end
        end
    end

    localparam logic [5:0] OPS [12] = '{6'h00, 6'h23, 6'h2B, 6'h08,
        6'h0C, 6'h0D, 6'h0A, 6'h0F, 6'h04, 6'h05, 6'h02, 6'h3F};

    initial begin
        logic [31:0] ri;
        rst_n = 0; if_instr = 0; if_pc_plus4 = 0;
        wb_we = 0; wb_addr = 0; wb_data = 0;
        ex_reg_write = 0; ex_mem_read = 0; ex_dest = 0;
        mem_mem_read = 0; mem_dest = 0;
        m_instr = 0; m_pc = 0; m_valid = 0;
        foreach (mreg[i]) mreg[i] = 0;

        step(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        step(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        lit(3, 0); lit(7, 0); lit(0, 0); lit(1, 0);
        step(1, rtype(5, 0, 3), 32'h4, 1, 5, 32'h1234, 0, 0, 0, 0, 0);
        lit(3, 0); lit(7, 0); lit(0, 0);
        step(1, rtype(7, 0, 2), 32'h8, 1, 0, 32'hFFFF_FFFF,
             0, 0, 0, 0, 0);
        lit(0, 32'h1234); lit(7, 9'b100100_010);
        step(1, rtype(4, 1, 2), 32'hC, 1, 7, 32'hAA, 0, 0, 0, 0, 0);
        lit(0, 32'hAA); lit(1, 0);
        step(1, itype(6'h0D, 1, 1, 16'h1), 32'h10, 1, 1, 9,
             0, 1, 4, 0, 0);
        lit(3, 1); lit(7, 0);
        step(1, itype(6'h04, 1, 2, 16'hFFFF), 32'h100, 1, 2, 9,
             0, 0, 0, 0, 0);
        lit(3, 0); lit(7, 9'b100100_010); lit(8, 4);
        step(1, itype(6'h08, 0, 1, 16'h1), 32'h104, 0, 0, 0,
             0, 0, 0, 0, 0);
        lit(4, 1); lit(5, 1); lit(6, 32'hFC); lit(7, 9'b1);
        step(1, itype(6'h04, 1, 2, 16'hFFFF), 32'h100, 1, 2, 8,
             0, 0, 0, 0, 0);
        lit(4, 0); lit(7, 0);
        step(1, {6'h02, 26'h40}, 32'h8000_0004, 0, 0, 0,
             0, 0, 0, 0, 0);
        lit(4, 0);
        step(1, itype(6'h0C, 0, 1, 16'h8000), 32'h8000_0008, 0, 0, 0,
             0, 0, 0, 0, 0);
        lit(4, 1); lit(5, 1); lit(6, 32'h8000_0100);
        step(1, itype(6'h0C, 0, 1, 16'h8000), 32'h200, 0, 0, 0,
             0, 0, 0, 0, 0);
        step(1, itype(6'h08, 0, 1, 16'h8000), 32'h204, 0, 0, 0,
             0, 0, 0, 0, 0);
        lit(2, 32'h0000_8000);
        step(1, itype(6'h04, 3, 0, 16'h5), 32'h208, 0, 0, 0,
             0, 0, 0, 0, 0);
        lit(2, 32'hFFFF_8000);
        step(0, itype(6'h08, 0, 1, 16'h1), 32'h20C, 0, 0, 0,
             1, 0, 3, 0, 0);
        lit(3, 1); lit(4, 0);
        step(1, 0, 32'h210, 0, 0, 0, 1, 0, 3, 0, 0);
        lit(3, 0); lit(7, 0);

        for (int n = 0; n < 3000; n++) begin
            ri = {OPS[$urandom_range(0, 11)],
                  5'($urandom_range(0, 7)), 5'($urandom_range(0, 7)),
                  16'($urandom)};
            step(($urandom % 64) != 0, ri, $urandom & 32'hFFFF_FFFC,
                 $urandom % 2, 5'($urandom_range(0, 7)),
                 ($urandom % 4 == 0) ? $urandom_range(0, 3) : $urandom,
                 $urandom % 2, ($urandom % 4) == 0,
                 5'($urandom_range(0, 7)), ($urandom % 4) == 0,
                 5'($urandom_range(0, 7)));
        end

        repeat (2) @(negedge clk);
        chk("queue_drained", q.size() + lq.size(), 0);
        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end

endmodule

// File: doc/id_stage.md
Name: id_stage

Overview:
- MIPS instruction-decode stage, directly upstream of the ID/EX pipeline register.
- Contains the IF/ID latch, a 32x32 register file, the main control decoder, immediate extension, early branch/jump resolution, and load-use/branch hazard detection.
- Decoded operands and control feed ID/EX combinationally from the latched instruction.
- Drives stall/flush/redirect back to the fetch stage.

Parameters:
- NREG, 32, register-file depth (r0 hardwired zero)
- XLEN, 32, datapath width

Ports:
- clk  in  1  clock; all state updates on rising edge
- rst_n  in  1  synchronous active-low reset
- if_instr  in  32  fetched instruction
- if_pc_plus4  in  32  PC+4 of fetched instruction
- wb_we  in  1  write-back enable
- wb_addr  in  5  write-back register
- wb_data  in  32  write-back data
- ex_reg_write  in  1  instruction in EX writes a register
- ex_mem_read  in  1  instruction in EX is a load
- ex_dest  in  5  destination register of EX instruction
- mem_mem_read  in  1  instruction in MEM is a load
- mem_dest  in  5  destination register of MEM instruction
- rs_data, rt_data  out  32  operand values, after WB bypass
- imm_ext  out  32  extended immediate
- rs, rt, rd  out  5  register fields
- shamt  out  5  shift amount
- funct  out  6  function field
- reg_dst, alu_src, mem_to_reg, reg_write, mem_read, mem_write  out  1 each  control to ID/EX
- alu_op  out  3  000 add, 001 sub, 010 use funct, 011 and, 100 or, 101 slt, 110 lui
- stall  out  1  hold PC and IF/ID
- pc_src  out  1  redirect fetch
- pc_target  out  32  redirect address
- flush_if  out  1  squash instruction being fetched

Behaviour:
- Reset (rst_n=0 at a clk edge):
  - IF/ID instr=0 (NOP), pc_plus4=0, valid=0.
  - All registers cleared.
  - The following cycle all control outputs, stall, pc_src and flush_if are 0.
- Reset overrides the WB write and stall in the same cycle.
- IF/ID latch update priority:
  - stall=1: hold.
  - Else flush_if=1: load instr=0, valid=0.
  - Else: load if_instr/if_pc_plus4, valid=1.
- Register file:
  - Write on clk edge when wb_we && wb_addr!=0.
  - Reads are combinational.
  - WB bypass: if wb_we && wb_addr!=0 && wb_addr==rs (or rt), output wb_data.
  - Reads of r0 always return 0.
- Decode by opcode; valid=0 forces all control 0.
  - R-type 0x00: reg_dst=1, reg_write=1, alu_op=010.
  - lw 0x23: alu_src=1, mem_to_reg=1, reg_write=1, mem_read=1, alu_op=000.
  - sw 0x2B: alu_src=1, mem_write=1, alu_op=000.
  - addi 0x08: alu_src=1, reg_write=1, alu_op=000.
  - andi 0x0C: alu_op=011. ori 0x0D: alu_op=100. slti 0x0A: alu_op=101. lui 0x0F: alu_op=110. Each also alu_src=1, reg_write=1.
  - beq 0x04, bne 0x05: alu_op=001, no writes.
  - j 0x02: no writes.
  - Unknown opcode: all control 0 (treated as NOP).
- imm_ext:
  - Zero-extend for andi/ori.
  - Sign-extend otherwise.
  - lui extension is left to ALU (alu_op 110).
- Hazard detection; stall=1 when valid and any of:
  - Load-use: ex_mem_read && ex_dest!=0 && (ex_dest==rs || (ex_dest==rt && rt is a source)). rt is a source for R-type, sw, beq, bne.
  - Branch dependency: beq/bne && ex_reg_write && ex_dest!=0 && ex_dest matches rs/rt.
  - Branch-on-load: beq/bne && mem_mem_read && mem_dest!=0 && mem_dest matches rs/rt.
- While stall=1: all control outputs forced 0 (bubble into ID/EX); pc_src=0; flush_if=0.
- Branch/jump resolution, when not stalled:
  - beq taken if rs_data==rt_data; bne taken if unequal.
  - Taken target: pc_plus4 + (imm_ext<<2), modulo 2^32.
  - j target: {pc_plus4[31:28], instr[25:0], 2'b00}.
  - Taken branch or j: pc_src=1, flush_if=1, same cycle (one-cycle penalty).
- Simultaneous WB write to a register and a branch reading it: the bypassed value is used.

Decomposition:
- Shared package mips_pkg: opcode constants, alu_op encodings, NOP constant, control-bundle struct.
- Sub-module regfile (NREG x XLEN, sync reset, write-through bypass).
- Decode and hazard logic live inline.

Test Plan:
- Reset, then reset deasserted -> rs_data=rt_data=0, all control 0, stall=0; after writing r5=0x1234 via WB, decode `add r3,r5,r0` -> rs_data=0x1234, reg_dst=1, reg_write=1, alu_op=010.
- WB write r0=0xFFFF_FFFF -> later read of r0 returns 0. Same-cycle WB r7=0xAA and decode reading r7 -> rs_data=0xAA.
- EX holds `lw r4` (ex_mem_read=1, ex_dest=4) while ID decodes `add r2,r4,r1` -> stall=1, control 0, IF/ID holds for one cycle. Next cycle, with ex_mem_read=0 -> stall=0 and decode proceeds.
- `beq r1,r2,-1` with r1=r2=9 at pc_plus4=0x100 -> pc_src=1, pc_target=0xFC, flush_if=1; next cycle valid=0 and control 0. With r2=8 -> pc_src=0.
- `j 0x0000040` at pc_plus4=0x8000_0004 -> pc_target=0x8000_0100, flush_if=1. `andi` with imm 0x8000 -> imm_ext=0x0000_8000; `addi` with 0x8000 -> 0xFFFF_8000.
- Branch reading r3 while ex_reg_write=1, ex_dest=3 -> stall=1 for that cycle; also assert reset mid-stall -> IF/ID cleared, stall=0 next cycle.
